// File: rtl/mbus_addr_rf_bank_pkg.sv
// Shared definitions for the MBus address register-file bank.
//
// Provides the default address width (`DYNA), the all-ones pattern used as
// the default "unassigned slot" value, the bank FSM state encoding and a
// helper that sizes slot-index fields.
//
// No ports (package).

`ifndef DYNA
`define DYNA 4
`endif

package mbus_addr_rf_bank_pkg;

  // Wide all-ones source; users slice it down to their address width.
  localparam logic [63:0] MBUS_INVALID_ADDR_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SWEEP = 2'd2
  } mbus_state_e;

  // Width of a slot index; a one-slot bank still gets a 1-bit field.
  function automatic int mbus_slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/mbus_addr_rf_bank_match.sv
// mbus_addr_match: combinational, valid-masked address comparator.
//
// Compares a key against every slot of a flattened address vector and
// reports whether any valid slot matches, plus the lowest matching index.
//
// Ports:
//   addr_vec   in   NUM_SLOTS*ADDR_W  slot i at [i*ADDR_W +: ADDR_W]
//   valid_vec  in   NUM_SLOTS         per-slot valid flag
//   key        in   ADDR_W            address to search for
//   hit        out  1                 some valid slot equals key
//   hit_idx    out  SLOT_W            lowest matching index (0 on miss)

module mbus_addr_match #(
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 4,
  parameter int SLOT_W    = 2
) (
  input  logic [NUM_SLOTS*ADDR_W-1:0] addr_vec,
  input  logic [NUM_SLOTS-1:0]        valid_vec,
  input  logic [ADDR_W-1:0]           key,
  output logic                        hit,
  output logic [SLOT_W-1:0]           hit_idx
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_vec[i] && (addr_vec[i*ADDR_W +: ADDR_W] == key)) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/mbus_addr_rf_bank.sv
// mbus_addr_rf_bank: bank of assignable MBus addresses with write, clear,
// clear-all sweep and a registered lookup port.
//
// Ports:
//   CLK                          in   1        sole clock, rising edge
//   RESET                        in   1        synchronous, active-high reset
//   RELEASE_ISO_FROM_SLEEP_CTRL  in   1        1 = isolation, updates blocked
//   WR_REQ / WR_SLOT / WR_ADDR   in            write request (held to WR_ACK)
//   WR_ACK / WR_ERR              out  1        write done pulse / rejected
//   CLR_REQ / CLR_ALL / CLR_SLOT in            clear request (held to CLR_ACK)
//   CLR_ACK                      out  1        clear done pulse
//   LOOKUP_VALID / LOOKUP_ADDR   in            lookup strobe and key
//   HIT / HIT_SLOT               out           registered lookup result
//   ADDR_OUT                     out  N*AW     all slots, slot i at [i*AW +: AW]
//   ADDR_VALID                   out  N        per-slot valid flags
//   BUSY                         out  1        FSM not idle
//
// state  | meaning
// IDLE   | accepting requests when not isolated; single clears finish here
// WRITE  | first cycle: commit or reject the write; second cycle: WR_ACK high
// SWEEP  | clearing one slot per cycle, index from the sweep counter

module mbus_addr_rf_bank
  import mbus_addr_rf_bank_pkg::*;
#(
  parameter  int                NUM_SLOTS    = 4,
  parameter  int                ADDR_W       = `DYNA,
  parameter  logic [ADDR_W-1:0] INVALID_ADDR = MBUS_INVALID_ADDR_ALL[ADDR_W-1:0],
  localparam int                SLOT_W       = mbus_slot_w(NUM_SLOTS)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        RELEASE_ISO_FROM_SLEEP_CTRL,
  input  logic                        WR_REQ,
  input  logic [SLOT_W-1:0]           WR_SLOT,
  input  logic [ADDR_W-1:0]           WR_ADDR,
  output logic                        WR_ACK,
  output logic                        WR_ERR,
  input  logic                        CLR_REQ,
  input  logic                        CLR_ALL,
  input  logic [SLOT_W-1:0]           CLR_SLOT,
  output logic                        CLR_ACK,
  input  logic                        LOOKUP_VALID,
  input  logic [ADDR_W-1:0]           LOOKUP_ADDR,
  output logic                        HIT,
  output logic [SLOT_W-1:0]           HIT_SLOT,
  output logic [NUM_SLOTS*ADDR_W-1:0] ADDR_OUT,
  output logic [NUM_SLOTS-1:0]        ADDR_VALID,
  output logic                        BUSY
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  mbus_state_e                 state_q, state_d;
  logic [SLOT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_SLOTS*ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_SLOTS-1:0]        valid_q, valid_d;
  logic                        wr_ack_q, wr_ack_d;
  logic                        wr_err_q, wr_err_d;
  logic                        clr_ack_q, clr_ack_d;
  logic                        hit_q, hit_d;
  logic [SLOT_W-1:0]           hit_slot_q, hit_slot_d;

  logic                        iso;
  logic                        sweep_ack;
  logic                        wr_slot_ok;
  logic                        clr_slot_ok;
  logic                        wr_reject;
  logic                        dup_hit;
  logic [SLOT_W-1:0]           dup_idx;
  logic                        lk_hit;
  logic [SLOT_W-1:0]           lk_idx;

  assign iso         = RELEASE_ISO_FROM_SLEEP_CTRL;
  assign wr_slot_ok  = (int'(WR_SLOT) < NUM_SLOTS);
  assign clr_slot_ok = (int'(CLR_SLOT) < NUM_SLOTS);

  // Lookup port: always compares against the current (pre-update) contents.
  mbus_addr_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .ADDR_W    (ADDR_W),
    .SLOT_W    (SLOT_W)
  ) u_lookup_match (
    .addr_vec  (addr_q),
    .valid_vec (valid_q),
    .key       (LOOKUP_ADDR),
    .hit       (lk_hit),
    .hit_idx   (lk_idx)
  );

  // Duplicate check for writes. Valid addresses are kept pairwise distinct
  // (every accepted write passes this check), so a hit names the single
  // slot holding WR_ADDR; a hit on the target slot itself is a harmless
  // rewrite.
  mbus_addr_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .ADDR_W    (ADDR_W),
    .SLOT_W    (SLOT_W)
  ) u_dup_match (
    .addr_vec  (addr_q),
    .valid_vec (valid_q),
    .key       (WR_ADDR),
    .hit       (dup_hit),
    .hit_idx   (dup_idx)
  );

  assign wr_reject = !wr_slot_ok
                  || (WR_ADDR == INVALID_ADDR)
                  || (dup_hit && (dup_idx != WR_SLOT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    wr_ack_d  = 1'b0;
    wr_err_d  = 1'b0;
    clr_ack_d = 1'b0;
    sweep_ack = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // While the single-clear ack is showing, CLR_REQ is still the old
        // request; ignoring it keeps CLR_ACK to a one-cycle pulse.
        if (!iso) begin
          if (CLR_REQ && !clr_ack_q) begin
            if (CLR_ALL) begin
              state_d = ST_SWEEP;
              cnt_d   = '0;
            end else begin
              if (clr_slot_ok) begin
                addr_d[CLR_SLOT*ADDR_W +: ADDR_W] = INVALID_ADDR;
                valid_d[CLR_SLOT]                 = 1'b0;
              end
              clr_ack_d = 1'b1;
            end
          end else if (WR_REQ) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // Isolation is deliberately ignored here so an accepted write
        // always completes.
        if (!wr_ack_q) begin
          wr_ack_d = 1'b1;
          if (wr_reject) begin
            wr_err_d = 1'b1;
          end else begin
            addr_d[WR_SLOT*ADDR_W +: ADDR_W] = WR_ADDR;
            valid_d[WR_SLOT]                 = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SWEEP: begin
        if (!iso) begin
          addr_d[cnt_q*ADDR_W +: ADDR_W] = INVALID_ADDR;
          valid_d[cnt_q]                 = 1'b0;
          if (cnt_q == LAST_SLOT) begin
            sweep_ack = !RESET;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + SLOT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hit_d      = LOOKUP_VALID && lk_hit;
    hit_slot_d = '0;
    if (hit_d) begin
      hit_slot_d = lk_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= {NUM_SLOTS{INVALID_ADDR}};
      valid_q    <= '0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      clr_ack_q  <= 1'b0;
      hit_q      <= 1'b0;
      hit_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
      clr_ack_q  <= clr_ack_d;
      hit_q      <= hit_d;
      hit_slot_q <= hit_slot_d;
    end
  end

  // The sweep ack is raised during the cycle whose closing edge clears the
  // last slot, so it lines up with that slot rather than trailing it.
  assign WR_ACK     = wr_ack_q;
  assign WR_ERR     = wr_err_q;
  assign CLR_ACK    = clr_ack_q | sweep_ack;
  assign HIT        = hit_q;
  assign HIT_SLOT   = hit_slot_q;
  assign ADDR_OUT   = addr_q;
  assign ADDR_VALID = valid_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mbus_addr_rf_bank.sv
// Self-checking bench for mbus_addr_rf_bank (4 slots, 4-bit addresses).
// A slot array model applies the bank's rules directly; directed scenarios
// are followed by randomized writes, lookups and clears.

module tb_mbus_addr_rf_bank;

  logic        clk;
  logic        RESET;
  logic        iso;
  logic        WR_REQ;
  logic [1:0]  WR_SLOT;
  logic [3:0]  WR_ADDR;
  logic        WR_ACK;
  logic        WR_ERR;
  logic        CLR_REQ;
  logic        CLR_ALL;
  logic [1:0]  CLR_SLOT;
  logic        CLR_ACK;
  logic        LOOKUP_VALID;
  logic [3:0]  LOOKUP_ADDR;
  logic        HIT;
  logic [1:0]  HIT_SLOT;
  logic [15:0] ADDR_OUT;
  logic [3:0]  ADDR_VALID;
  logic        BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] model_addr  [4];
  logic       model_valid [4];

  mbus_addr_rf_bank #(
    .NUM_SLOTS (4),
    .ADDR_W    (4)
  ) dut (
    .CLK                         (clk),
    .RESET                       (RESET),
    .RELEASE_ISO_FROM_SLEEP_CTRL (iso),
    .WR_REQ                      (WR_REQ),
    .WR_SLOT                     (WR_SLOT),
    .WR_ADDR                     (WR_ADDR),
    .WR_ACK                      (WR_ACK),
    .WR_ERR                      (WR_ERR),
    .CLR_REQ                     (CLR_REQ),
    .CLR_ALL                     (CLR_ALL),
    .CLR_SLOT                    (CLR_SLOT),
    .CLR_ACK                     (CLR_ACK),
    .LOOKUP_VALID                (LOOKUP_VALID),
    .LOOKUP_ADDR                 (LOOKUP_ADDR),
    .HIT                         (HIT),
    .HIT_SLOT                    (HIT_SLOT),
    .ADDR_OUT                    (ADDR_OUT),
    .ADDR_VALID                  (ADDR_VALID),
    .BUSY                        (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < 4; i++) begin
      model_addr[i]  = 4'hF;
      model_valid[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = model_addr[i];
    return v;
  endfunction

  function automatic logic [3:0] model_vld();
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = model_valid[i];
    return v;
  endfunction

  function automatic logic ref_reject(input int slot, input logic [3:0] a);
    if (slot >= 4) return 1'b1;
    if (a == 4'hF) return 1'b1;
    for (int j = 0; j < 4; j++)
      if (j != slot && model_valid[j] && model_addr[j] == a) return 1'b1;
    return 1'b0;
  endfunction

  // {hit, slot}: lowest valid slot holding the address.
  function automatic logic [2:0] ref_lookup(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (model_valid[i] && model_addr[i] == a) return {1'b1, 2'(i)};
    return 3'b000;
  endfunction

  task automatic check_slots(input string tag);
    check({tag, "_addr_out"}, ADDR_OUT, model_out());
    check({tag, "_addr_valid"}, ADDR_VALID, model_vld());
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    model_clear_all();
  endtask

  // Write with optional isolation held for iso_cycles before release.
  task automatic do_write(input int slot, input logic [3:0] a, input int iso_cycles);
    int   lat;
    logic exp_err;
    logic stray;
    exp_err = ref_reject(slot, a);
    WR_SLOT = 2'(slot);
    WR_ADDR = a;
    WR_REQ  = 1'b1;
    if (iso_cycles > 0) begin
      iso   = 1'b1;
      stray = 1'b0;
      repeat (iso_cycles) begin
        tick();
        if (WR_ACK || BUSY) stray = 1'b1;
      end
      check("iso_write_stalled", stray, 1'b0);
      check_slots("iso_write_hold");
      iso = 1'b0;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!WR_ACK && lat < 10);
    check("wr_latency", lat, 2);
    check("wr_err", WR_ERR, exp_err);
    if (!exp_err) begin
      model_addr[slot]  = a;
      model_valid[slot] = 1'b1;
    end
    check_slots("wr_contents");
    WR_REQ = 1'b0;
    tick();
    check("wr_ack_one_cycle", {WR_ACK, WR_ERR}, 2'b00);
  endtask

  task automatic do_clear(input int slot);
    CLR_REQ  = 1'b1;
    CLR_ALL  = 1'b0;
    CLR_SLOT = 2'(slot);
    tick();
    check("clr_ack", CLR_ACK, 1'b1);
    model_addr[slot]  = 4'hF;
    model_valid[slot] = 1'b0;
    check_slots("clr_contents");
    CLR_REQ = 1'b0;
    tick();
    check("clr_ack_one_cycle", CLR_ACK, 1'b0);
  endtask

  task automatic fill4();
    do_write(0, 4'h1, 0);
    do_write(1, 4'h2, 0);
    do_write(2, 4'h5, 0);
    do_write(3, 4'h9, 0);
  endtask

  // iso_at > 0: raise isolation at that busy cycle for iso_len cycles.
  task automatic do_clear_all(input int iso_at, input int iso_len);
    int busy_n;
    int ack_n;
    int ack_at;
    int guard;
    CLR_REQ = 1'b1;
    CLR_ALL = 1'b1;
    busy_n  = 0;
    ack_n   = 0;
    ack_at  = 0;
    guard   = 0;
    tick();
    while (BUSY && guard < 40) begin
      busy_n++;
      guard++;
      if (CLR_ACK) begin
        ack_n++;
        ack_at  = busy_n;
        CLR_REQ = 1'b0;
      end
      if (iso_at == 0)
        check("sweep_progress", ADDR_VALID, (64'hF << (busy_n - 1)) & 64'hF);
      if (iso_at > 0 && busy_n == iso_at) iso = 1'b1;
      if (iso_at > 0 && busy_n == iso_at + iso_len) iso = 1'b0;
      tick();
    end
    CLR_REQ = 1'b0;
    iso     = 1'b0;
    check("sweep_busy_cycles", busy_n, 4 + iso_len);
    check("sweep_ack_count", ack_n, 1);
    check("sweep_ack_on_last", ack_at, 4 + iso_len);
    model_clear_all();
    check_slots("sweep_done");
    check("sweep_ack_after", CLR_ACK, 1'b0);
  endtask

  initial begin
    logic [2:0] exp_lk;
    logic       late_ack;

    RESET        = 1'b1;
    iso          = 1'b0;
    WR_REQ       = 1'b0;
    WR_SLOT      = '0;
    WR_ADDR      = '0;
    CLR_REQ      = 1'b0;
    CLR_ALL      = 1'b0;
    CLR_SLOT     = '0;
    LOOKUP_VALID = 1'b0;
    LOOKUP_ADDR  = '0;
    model_clear_all();

    // Reset state.
    do_reset();
    check("rst_addr_out", ADDR_OUT, 16'hFFFF);
    check("rst_addr_valid", ADDR_VALID, 4'b0000);
    check("rst_outputs", {BUSY, WR_ACK, WR_ERR, CLR_ACK, HIT, HIT_SLOT}, 7'b0);

    // Basic write, then rejects and same-slot rewrite.
    do_write(2, 4'h5, 0);
    check("wr_slot2_valid", ADDR_VALID, 4'b0100);
    check("wr_slot2_addr", ADDR_OUT[11:8], 4'h5);
    do_write(1, 4'h5, 0);
    do_write(0, 4'hF, 0);
    do_write(2, 4'h5, 0);

    // Write held off by isolation for 5 cycles.
    do_write(1, 4'h3, 5);

    // Directed lookups.
    LOOKUP_VALID = 1'b1;
    LOOKUP_ADDR  = 4'h5;
    tick();
    check("lookup_5", {HIT, HIT_SLOT}, 3'b110);
    LOOKUP_ADDR = 4'h7;
    tick();
    check("lookup_7", {HIT, HIT_SLOT}, 3'b000);

    // Lookup of slot 2's address in the same cycle it is cleared.
    LOOKUP_ADDR = 4'h5;
    CLR_REQ     = 1'b1;
    CLR_ALL     = 1'b0;
    CLR_SLOT    = 2'd2;
    tick();
    check("lookup_vs_clear", {HIT, HIT_SLOT}, 3'b110);
    check("clear_concurrent_ack", CLR_ACK, 1'b1);
    model_addr[2]  = 4'hF;
    model_valid[2] = 1'b0;
    check_slots("clear_concurrent");
    CLR_REQ      = 1'b0;
    LOOKUP_VALID = 1'b0;
    tick();
    check("clear_concurrent_one_cycle", CLR_ACK, 1'b0);

    // Randomized writes (small address range to provoke duplicates).
    for (int k = 0; k < 24; k++)
      do_write(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0);

    // Randomized lookups against the model.
    for (int k = 0; k < 40; k++) begin
      LOOKUP_VALID = 1'($urandom_range(0, 1));
      LOOKUP_ADDR  = 4'($urandom_range(0, 15));
      exp_lk       = LOOKUP_VALID ? ref_lookup(LOOKUP_ADDR) : 3'b000;
      tick();
      check("rand_lookup", {HIT, HIT_SLOT}, exp_lk);
    end
    LOOKUP_VALID = 1'b0;

    // Randomized single clears.
    for (int k = 0; k < 4; k++)
      do_clear(int'($urandom_range(0, 3)));

    // Clear-all sweep, then with an isolation pulse mid-sweep.
    do_reset();
    fill4();
    do_clear_all(0, 0);
    fill4();
    do_clear_all(2, 3);

    // Reset during a sweep aborts it with no ack.
    fill4();
    CLR_REQ = 1'b1;
    CLR_ALL = 1'b1;
    tick();
    tick();
    check("pre_reset_sweep_busy", BUSY, 1'b1);
    RESET   = 1'b1;
    CLR_REQ = 1'b0;
    tick();
    model_clear_all();
    check_slots("reset_mid_sweep");
    check("reset_mid_sweep_flags", {BUSY, CLR_ACK, WR_ACK, HIT}, 4'b0000);
    RESET    = 1'b0;
    late_ack = 1'b0;
    repeat (6) begin
      tick();
      if (CLR_ACK || BUSY) late_ack = 1'b1;
    end
    check("reset_no_late_ack", late_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mbus_addr_rf_bank.md
MBUS_ADDR_RF_BANK -- requirements
Module: mbus_addr_rf_bank

Interface
REQ-001 Parameters SHALL be:
- NUM_SLOTS, default 4: number of address slots, minimum 1.
- ADDR_W, default `DYNA: width of one address.
- INVALID_ADDR, default all-ones: value of an unassigned slot.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  sole clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- RELEASE_ISO_FROM_SLEEP_CTRL  in  1  high = isolation; blocks all updates.
- WR_REQ  in  1  write request; held until WR_ACK.
- WR_SLOT  in  clog2(NUM_SLOTS)  target slot of the write.
- WR_ADDR  in  ADDR_W  address to store.
- WR_ACK  out  1  one-cycle completion pulse for a write.
- WR_ERR  out  1  valid with WR_ACK; 1 = write rejected.
- CLR_REQ  in  1  clear request; held until CLR_ACK.
- CLR_ALL  in  1  sampled with CLR_REQ; 1 = clear every slot.
- CLR_SLOT  in  clog2(NUM_SLOTS)  slot cleared when CLR_ALL = 0.
- CLR_ACK  out  1  one-cycle completion pulse for a clear.
- LOOKUP_VALID  in  1  lookup strobe.
- LOOKUP_ADDR  in  ADDR_W  address to match.
- HIT  out  1  registered lookup match.
- HIT_SLOT  out  clog2(NUM_SLOTS)  index of the matching slot.
- ADDR_OUT  out  NUM_SLOTS*ADDR_W  all slots; slot i at bits [i*ADDR_W +: ADDR_W].
- ADDR_VALID  out  NUM_SLOTS  per-slot valid flag.
- BUSY  out  1  high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WRITE, SWEEP.
REQ-004 Requests SHALL be accepted only in IDLE with RELEASE_ISO_FROM_SLEEP_CTRL low; during isolation, requests stay pending with no ack and all slots hold.
REQ-005 If CLR_REQ and WR_REQ are both high in IDLE, the clear SHALL win and the write SHALL stay pending.
REQ-006 A write accepted in IDLE SHALL:
- move to WRITE;
- on the next edge, either update the slot or reject it;
- pulse WR_ACK for one cycle in WRITE, then return to IDLE.
This gives 2-cycle request-to-ack latency.
REQ-007 A write SHALL be rejected (WR_ERR=1, no state change) when any of these hold:
- WR_SLOT >= NUM_SLOTS;
- WR_ADDR == INVALID_ADDR;
- WR_ADDR equals the valid address of a different slot.
Rewriting the same slot with its own address SHALL succeed.
REQ-008 A successful write SHALL set ADDR_OUT[slot]=WR_ADDR and ADDR_VALID[slot]=1.
REQ-009 A single clear (CLR_ALL=0) SHALL complete in one cycle from IDLE:
- set the slot to INVALID_ADDR with valid 0;
- pulse CLR_ACK on the following cycle;
- an out-of-range CLR_SLOT SHALL be acked with no effect.
REQ-010 A clear-all SHALL enter SWEEP and clear one slot per cycle, index 0 to NUM_SLOTS-1, using a slot counter.
- CLR_ACK SHALL pulse in the cycle the last slot clears; the FSM then returns to IDLE.
- Total latency SHALL be NUM_SLOTS cycles.
REQ-011 Isolation rising during SWEEP SHALL freeze the counter and slots; the sweep SHALL resume where it stopped when isolation falls. Isolation SHALL NOT affect WRITE completion or acks.
REQ-012 Lookup SHALL have 1-cycle latency, registered, and SHALL operate in every state including isolation.
- HIT=1 when LOOKUP_VALID and LOOKUP_ADDR matches a valid slot.
- HIT_SLOT SHALL be the lowest matching index.
- Otherwise HIT=0 and HIT_SLOT=0.
REQ-013 A lookup in the same cycle as a slot update SHALL compare against the pre-update contents.
REQ-014 WR_ACK, WR_ERR and CLR_ACK SHALL never be high for more than one consecutive cycle.

Reset
REQ-015 On RESET high at a clock edge, all of the following SHALL take effect, aborting any operation in progress:
- every ADDR_OUT slot = INVALID_ADDR and ADDR_VALID = 0;
- state = IDLE and sweep counter = 0;
- WR_ACK, WR_ERR, CLR_ACK, HIT, HIT_SLOT and BUSY = 0.
REQ-016 RESET SHALL take priority over isolation and all requests; no ack SHALL be issued for an aborted operation.

Structure
REQ-017 The FSM state encoding and the INVALID_ADDR default SHALL live in the shared mbus package/include next to `DYNA.
REQ-018 The lookup comparator SHALL be one sub-module, mbus_addr_match: combinational valid-masked compare with lowest-index priority. It SHALL be reused by the duplicate check in REQ-007.

Verification
REQ-019 Reset, then write slot2=0x5 -> WR_ACK 2 cycles after WR_REQ, WR_ERR=0, ADDR_VALID=4'b0100, ADDR_OUT slot2=0x5.
REQ-020 With slot2=0x5, write slot1=0x5 -> WR_ERR=1. Write slot0=0xF -> WR_ERR=1. Slot contents unchanged in both cases.
REQ-021 Isolation high, WR_REQ held 5 cycles -> no WR_ACK and no change. Isolation low -> WR_ACK 2 cycles later.
REQ-022 Four slots valid, clear-all -> BUSY for 4 cycles and CLR_ACK with the last slot. Isolation pulse mid-sweep -> completion stretched by the pulse length.
REQ-023 Lookup of 0x5 -> HIT=1, HIT_SLOT=2 next cycle. Lookup of 0x7 -> HIT=0. Lookup concurrent with a clear of slot2 -> HIT=1.
REQ-024 RESET asserted mid-sweep -> all slots INVALID_ADDR and valid=0 next cycle, no CLR_ACK.
